// File: rtl/cpu_cmd_arbiter_pkg.sv
// cpu_arb_pkg: shared definitions for the CPU command arbiter.
//   arb_state_t : arbiter FSM states
//   NOP_CMD     : command driven to the CPU whenever no command is being issued
//   CMD_W_DEF   : default command width
//   TMO_CNT_W   : width of the optional watchdog counter (CPU_ARB_TIMEOUT_EN)
package cpu_arb_pkg;

    localparam int CMD_W_DEF = 7;
    localparam int TMO_CNT_W = 16;

    localparam logic [CMD_W_DEF-1:0] NOP_CMD = 7'h00;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } arb_state_t;

endpackage

// File: rtl/cpu_cmd_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports:
//   req         in  NREQ   request vector
//   ptr         in  IDX_W  index with highest priority this round
//   grant_valid out 1      at least one request is set
//   grant_idx   out IDX_W  first set request found from ptr upward, with wrap
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    int j;

    // Scan offsets from the far end down to zero so the last hit written is
    // the one closest to ptr; avoids a break/found flag.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[j[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cpu_cmd_arbiter.sv
// cpu_cmd_arbiter: shares one CPU datapath between NREQ requesters.
// A request is accepted round-robin, its command is driven to the CPU until
// the CPU drops cpu_rdy, then the arbiter waits for cpu_rdy to rise again and
// captures result/zero/error, returning them to the granted requester.
//
// Handshakes:
//   request : requester holds req_valid[i]/req_cmd slice until it sees the
//             one-cycle req_ack[i] pulse; dropping earlier just withdraws it.
//   response: rsp_valid[gnt_id] and rsp_* stay stable until the cycle
//             rsp_ready[gnt_id]=1; rsp_ready of other requesters is ignored.
//
// Ports:
//   clk, reset (async, active-high)
//   req_valid/req_cmd/req_ack        request side (req_cmd flattened, CMD_W each)
//   rsp_valid/rsp_ready/rsp_data/rsp_zero/rsp_error/rsp_timeout  response side
//   cpu_cmd/cpu_rdy/cpu_result/cpu_zero/cpu_error                CPU side
//   busy    arbiter not idle
//   gnt_id  current or last granted requester
//
// Optional feature: define CPU_ARB_TIMEOUT_EN to enable a watchdog that
// aborts a command after TMO_CYCLES cycles in ISSUE/WAIT_DONE with
// rsp_error=1, rsp_timeout=1, rsp_data=0.
module cpu_cmd_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CMD_W      = CMD_W_DEF,
    parameter int NREQ       = 2,
    parameter int TMO_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*CMD_W-1:0]    req_cmd,
    output logic [NREQ-1:0]          req_ack,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_data,
    output logic                     rsp_zero,
    output logic                     rsp_error,
    output logic                     rsp_timeout,
    output logic [CMD_W-1:0]         cpu_cmd,
    input  logic                     cpu_rdy,
    input  logic [2*WIDTH-1:0]       cpu_result,
    input  logic                     cpu_zero,
    input  logic                     cpu_error,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  gnt_id
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [CMD_W-1:0] NOP = CMD_W'(NOP_CMD);
    localparam logic [NREQ-1:0]  ONE = {{(NREQ-1){1'b0}}, 1'b1};

    if (NREQ < 2 || NREQ > 4 || TMO_CYCLES < 1) begin : g_bad_cfg
        $error("cpu_cmd_arbiter: NREQ must be 2..4 and TMO_CYCLES >= 1");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;

    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [CMD_W-1:0] grant_cmd;
    logic [NREQ-1:0]  grant_oh;
    logic [NREQ-1:0]  gnt_oh;
    logic             start;
    logic             tmo_hit;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign grant_cmd = req_cmd[int'(grant_idx)*CMD_W +: CMD_W];
    assign grant_oh  = ONE << grant_idx;
    assign gnt_oh    = ONE << gnt_id;

    // Arbitration only happens while the CPU reports idle.
    assign start = (state == IDLE) && cpu_rdy && grant_valid;

`ifdef CPU_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] tmo_cnt;

    // Counts cycles spent in ISSUE/WAIT_DONE; the hit fires on the
    // TMO_CYCLES-th such cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (start) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE || state == WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
        end
    end

    assign tmo_hit = (state == ISSUE || state == WAIT_DONE) &&
                     (tmo_cnt == TMO_CNT_W'(TMO_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gnt_id      <= '0;
            cpu_cmd     <= NOP;
            req_ack     <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_zero    <= 1'b0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            req_ack <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        req_ack <= grant_oh;
                        gnt_id  <= grant_idx;
                        cpu_cmd <= grant_cmd;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // cpu_rdy falling means the CPU has taken the command.
                    if (!cpu_rdy) begin
                        cpu_cmd <= NOP;
                        state   <= WAIT_DONE;
                    end else if (tmo_hit) begin
                        cpu_cmd     <= NOP;
                        rsp_data    <= '0;
                        rsp_zero    <= 1'b0;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= gnt_oh;
                        state       <= RESP;
                    end
                end
                WAIT_DONE: begin
                    // Normal completion wins over a watchdog hit in the same cycle.
                    if (cpu_rdy) begin
                        rsp_data    <= cpu_result;
                        rsp_zero    <= cpu_zero;
                        rsp_error   <= cpu_error;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= gnt_oh;
                        state       <= RESP;
                    end else if (tmo_hit) begin
                        cpu_cmd     <= NOP;
                        rsp_data    <= '0;
                        rsp_zero    <= 1'b0;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= gnt_oh;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[gnt_id]) begin
                        rsp_valid <= '0;
                        rr_ptr    <= (gnt_id == IDX_W'(NREQ - 1)) ? '0 : gnt_id + IDX_W'(1);
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_cmd_arbiter.sv
// Self-checking bench for cpu_cmd_arbiter (NREQ=2, WIDTH=8, TMO_CYCLES=8).
// Inputs change 1 time unit after the rising edge; the response monitor
// samples at the falling edge and compares each handshake against exp_q.
module tb_cpu_cmd_arbiter;

    localparam int WIDTH = 8;
    localparam int CMD_W = 7;
    localparam int NREQ  = 2;
    localparam int EW    = 20;  // {id, timeout, error, zero, data[15:0]}

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*CMD_W-1:0] req_cmd;
    logic [NREQ-1:0]       req_ack;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [2*WIDTH-1:0]    rsp_data;
    logic                  rsp_zero;
    logic                  rsp_error;
    logic                  rsp_timeout;
    logic [CMD_W-1:0]      cpu_cmd;
    logic                  cpu_rdy;
    logic [2*WIDTH-1:0]    cpu_result;
    logic                  cpu_zero;
    logic                  cpu_error;
    logic                  busy;
    logic                  gnt_id;

    logic [EW-1:0] exp_q[$];
    int n_vec  = 0;
    int n_fail = 0;

    cpu_cmd_arbiter #(
        .WIDTH      (WIDTH),
        .CMD_W      (CMD_W),
        .NREQ       (NREQ),
        .TMO_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_cmd     (req_cmd),
        .req_ack     (req_ack),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .cpu_cmd     (cpu_cmd),
        .cpu_rdy     (cpu_rdy),
        .cpu_result  (cpu_result),
        .cpu_zero    (cpu_zero),
        .cpu_error   (cpu_error),
        .busy        (busy),
        .gnt_id      (gnt_id)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One complete transaction for requester id. Caller sets req_valid/req_cmd
    // beforehand; the arbiter is expected to grant id at the first edge.
    task automatic serve(input int id, input logic [6:0] cmd, input int exec,
                         input logic [15:0] res, input logic z, input logic e,
                         input int hold);
        logic [1:0] oh;
        oh = 2'b01 << id;
        tick();
        chk("ack", 32'(req_ack), 32'(oh));
        chk("gnt_id", 32'(gnt_id), 32'(id));
        chk("cpu_cmd_issue", 32'(cpu_cmd), 32'(cmd));
        chk("busy_issue", 32'(busy), 32'd1);
        req_valid[id] = 1'b0;
        tick();
        chk("ack_pulse", 32'(req_ack), 32'd0);
        chk("cpu_cmd_hold", 32'(cpu_cmd), 32'(cmd));
        cpu_rdy = 1'b0;
        tick();
        chk("cpu_cmd_nop", 32'(cpu_cmd), 32'h00);
        repeat (exec - 1) tick();
        cpu_result = res;
        cpu_zero   = z;
        cpu_error  = e;
        cpu_rdy    = 1'b1;
        exp_q.push_back({id[0], 1'b0, e, z, res});
        tick();
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        cpu_zero  = ~z;
        cpu_error = ~e;
        rsp_ready = ~oh;
        for (int c = 0; c < hold; c++) begin
            cpu_result = 16'($urandom);
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'(oh));
            chk("bp_data", 32'({rsp_zero, rsp_error, rsp_data}), 32'({z, e, res}));
            chk("bp_no_ack", 32'(req_ack), 32'd0);
        end
        rsp_ready = oh;
        tick();
        rsp_ready = '0;
        chk("rsp_clear", 32'(rsp_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got response for %0d data %0h, expected none", i, rsp_data);
                    end else begin
                        chk("rsp", 32'({i[0], rsp_timeout, rsp_error, rsp_zero, rsp_data}),
                            32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_cmd    = '0;
        rsp_ready  = '0;
        cpu_rdy    = 1'b1;
        cpu_result = '0;
        cpu_zero   = 1'b0;
        cpu_error  = 1'b0;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cpu_cmd", 32'(cpu_cmd), 32'h00);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_rsp", 32'({rsp_timeout, rsp_error, rsp_zero, rsp_data}), 32'd0);
        reset = 1'b0;

        // 1: single request
        req_cmd[6:0] = 7'h15;
        req_valid    = 2'b01;
        serve(0, 7'h15, 5, 16'h00A5, 1'b0, 1'b0, 0);

        // 2: simultaneous requests from reset, order 0,1,0,1
        do_reset();
        req_cmd   = {7'h2A, 7'h11};
        req_valid = 2'b11;
        serve(0, 7'h11, 2, 16'h1234, 1'b0, 1'b0, 0);
        req_valid[0] = 1'b1;
        serve(1, 7'h2A, 3, 16'h0000, 1'b1, 1'b0, 1);
        req_valid[1] = 1'b1;
        serve(0, 7'h11, 1, 16'hFFFF, 1'b0, 1'b1, 0);
        serve(1, 7'h2A, 4, 16'h8001, 1'b0, 1'b0, 2);

        // 3: backpressure with the other requester pending
        req_cmd   = {7'h33, 7'h44};
        req_valid = 2'b11;
        serve(0, 7'h44, 3, 16'h5A5A, 1'b1, 1'b1, 10);
        serve(1, 7'h33, 2, 16'h00C3, 1'b0, 1'b0, 0);

        // 4: CPU not ready blocks arbitration
        cpu_rdy         = 1'b0;
        req_cmd[13:7]   = 7'h7F;
        req_valid       = 2'b10;
        repeat (3) begin
            tick();
            chk("notrdy_ack", 32'(req_ack), 32'd0);
            chk("notrdy_busy", 32'(busy), 32'd0);
        end
        cpu_rdy = 1'b1;
        serve(1, 7'h7F, 2, 16'hBEEF, 1'b0, 1'b0, 0);

        // 5: reset during WAIT_DONE
        req_cmd[6:0] = 7'h05;
        req_valid    = 2'b01;
        tick();
        chk("r5_ack", 32'(req_ack), 32'd1);
        req_valid = '0;
        tick();
        cpu_rdy = 1'b0;
        tick();
        chk("r5_nop", 32'(cpu_cmd), 32'h00);
        chk("r5_busy", 32'(busy), 32'd1);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("r5_busy_rst", 32'(busy), 32'd0);
        chk("r5_valid_rst", 32'(rsp_valid), 32'd0);
        chk("r5_cmd_rst", 32'(cpu_cmd), 32'h00);
        cpu_result = 16'h1111;
        cpu_rdy    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (4) begin
            tick();
            chk("r5_no_rsp", 32'(rsp_valid), 32'd0);
            chk("r5_idle", 32'(busy), 32'd0);
        end

`ifdef CPU_ARB_TIMEOUT_EN
        // 6: CPU never drops rdy -> watchdog response after 8 cycles
        req_cmd[6:0] = 7'h09;
        req_valid    = 2'b01;
        tick();
        chk("t6_ack", 32'(req_ack), 32'd1);
        req_valid = '0;
        repeat (7) begin
            tick();
            chk("t6_wait", 32'(rsp_valid), 32'd0);
        end
        exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
        tick();
        chk("t6_valid", 32'(rsp_valid), 32'd1);
        chk("t6_flags", 32'({rsp_timeout, rsp_error, rsp_zero, rsp_data}), 32'({1'b1, 1'b1, 1'b0, 16'h0000}));
        chk("t6_cmd", 32'(cpu_cmd), 32'h00);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;
        chk("t6_idle", 32'(busy), 32'd0);
`endif

        tick();
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
